// File: rtl/spi_cfg_pkg.sv
// Shared types and default frame geometry for the SPI configuration sequencer.
package spi_cfg_pkg;

  localparam int unsigned DEF_INST_W = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned RW_BIT     = DEF_INST_W - 1;
  localparam int unsigned FRAME_W    = DEF_INST_W + DEF_DATA_W;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/spi_cfg_shifter.sv
// SCLK divider plus TX/RX shift registers for one 3-wire SPI frame.
// A load pulse starts a frame; done pulses once after the last high half.
module spi_cfg_shifter
  import spi_cfg_pkg::*;
#(
  parameter int unsigned INST_W  = DEF_INST_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [INST_W+DATA_W-1:0] frame,
  input  logic                     sdio_i,
  output logic                     done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     is_read,
  output logic                     sclk,
  output logic                     csb,
  output logic                     sdio_o,
  output logic                     sdio_oe
);

  localparam int unsigned FrameW = INST_W + DATA_W;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BitW-1:0] BitLast   = BitW'(FrameW - 1);
  localparam logic [BitW-1:0] DataFirst = BitW'(INST_W);
  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);

  logic              active_q;
  logic              hi_q;
  logic [DivW-1:0]   div_q;
  logic [BitW-1:0]   bit_q;
  logic [FrameW-1:0] tx_q;
  logic [BitW-1:0]   bit_nxt;
  logic              sample;

  assign bit_nxt = bit_q + BitW'(1);
  // Slave data is captured on the first clk of each data bit's high half.
  assign sample  = active_q && hi_q && (div_q == '0) && is_read && (bit_q >= DataFirst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      hi_q     <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rdata    <= '0;
      is_read  <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      csb      <= 1'b1;
      sdio_o   <= 1'b1;
      sdio_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        active_q <= 1'b1;
        hi_q     <= 1'b0;
        div_q    <= '0;
        bit_q    <= '0;
        tx_q     <= {frame[FrameW-2:0], 1'b0};
        rdata    <= '0;
        is_read  <= frame[FrameW-1];
        sclk     <= 1'b0;
        csb      <= 1'b0;
        sdio_o   <= frame[FrameW-1];
        sdio_oe  <= 1'b1;
      end else if (active_q) begin
        if (sample) begin
          rdata <= {rdata[DATA_W-2:0], sdio_i};
        end
        if (div_q != DivLast) begin
          div_q <= div_q + DivW'(1);
        end else begin
          div_q <= '0;
          if (!hi_q) begin
            hi_q <= 1'b1;
            sclk <= 1'b1;
          end else if (bit_q == BitLast) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            done     <= 1'b1;
            sclk     <= 1'b0;
            csb      <= 1'b1;
            sdio_o   <= 1'b1;
            sdio_oe  <= 1'b0;
          end else begin
            hi_q    <= 1'b0;
            bit_q   <= bit_nxt;
            sclk    <= 1'b0;
            sdio_o  <= tx_q[FrameW-1];
            tx_q    <= {tx_q[FrameW-2:0], 1'b0};
            // Turn SDIO around to the slave for the data phase of a read.
            sdio_oe <= !(is_read && (bit_nxt >= DataFirst));
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_cfg_seq.sv
// Walks a ROM register table over 3-wire SPI after reset or start, then
// serves single host read/write frames.
module spi_cfg_seq
  import spi_cfg_pkg::*;
#(
  parameter int unsigned INST_W    = DEF_INST_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned TBL_AW    = 6,
  parameter int unsigned NUM_WORDS = 6,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [TBL_AW-1:0]        tbl_addr,
  input  logic [INST_W+DATA_W-1:0] tbl_data,
  input  logic                     host_req,
  input  logic [INST_W+DATA_W-1:0] host_word,
  output logic                     host_ack,
  output logic [DATA_W-1:0]        host_rdata,
  output logic                     sclk,
  output logic                     csb,
  output logic                     sdio_o,
  output logic                     sdio_oe,
  input  logic                     sdio_i,
  output logic                     busy,
  output logic                     spi_ok
);

  localparam int unsigned FrameW = INST_W + DATA_W;
  localparam int unsigned GapW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [GapW-1:0]   GapLast = GapW'(CS_GAP - 1);
  localparam logic [TBL_AW-1:0] IdxLast = TBL_AW'(NUM_WORDS - 1);

  state_e            state_q;
  logic [TBL_AW-1:0] idx_q;
  logic [GapW-1:0]   gap_q;
  logic              src_host_q;

  logic              sh_load;
  logic [FrameW-1:0] sh_frame;
  logic              sh_done;
  logic [DATA_W-1:0] sh_rdata;
  logic              sh_read;

  assign sh_load  = (state_q == StLoad);
  assign sh_frame = src_host_q ? host_word : tbl_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      idx_q      <= '0;
      gap_q      <= '0;
      src_host_q <= 1'b0;
      tbl_addr   <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      busy       <= 1'b1;
      spi_ok     <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StFetch;
            idx_q      <= '0;
            tbl_addr   <= '0;
            src_host_q <= 1'b0;
            spi_ok     <= 1'b0;
            busy       <= 1'b1;
          end else if (host_req && !host_ack) begin
            // The ack cycle is skipped so a request still held there is not re-run.
            state_q    <= StLoad;
            src_host_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StFetch: begin
          tbl_addr <= idx_q;
          state_q  <= StLoad;
        end
        StLoad: begin
          state_q <= StShift;
        end
        StShift: begin
          if (sh_done) begin
            gap_q   <= '0;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (gap_q != GapLast) begin
            gap_q <= gap_q + GapW'(1);
          end else if (src_host_q) begin
            host_ack   <= 1'b1;
            host_rdata <= sh_read ? sh_rdata : '0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end else if (idx_q != IdxLast) begin
            idx_q    <= idx_q + TBL_AW'(1);
            tbl_addr <= idx_q + TBL_AW'(1);
            state_q  <= StFetch;
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          spi_ok  <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  spi_cfg_shifter #(
    .INST_W  (INST_W),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .frame   (sh_frame),
    .sdio_i  (sdio_i),
    .done    (sh_done),
    .rdata   (sh_rdata),
    .is_read (sh_read),
    .sclk    (sclk),
    .csb     (csb),
    .sdio_o  (sdio_o),
    .sdio_oe (sdio_oe)
  );

endmodule
